// File: rtl/kan_tda_pkg.sv
// Shared definitions for the KAN PE feeder.
//   calc_spb : samples carried by one memory beat
//   calc_bpf : beats needed to fill one frame of PE samples
//   idx_w    : index width for a count of n items (minimum 1 bit)
//   kan_sample_t : one PE sample at the default sample width
package kan_tda_pkg;

    localparam int KAN_DATA_WIDTH = 16;

    typedef logic [KAN_DATA_WIDTH-1:0] kan_sample_t;

    function automatic int calc_spb(input int beat_w, input int data_w);
        return beat_w / data_w;
    endfunction

    function automatic int calc_bpf(input int num_pes, input int spb);
        return num_pes / spb;
    endfunction

    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/kan_feeder_bank.sv
// One frame buffer of NUM_PES samples, written a beat at a time.
//   clk       : clock
//   we        : write beat_data into beat slot beat_idx
//   beat_idx  : beat slot, covers lanes beat_idx*SPB .. beat_idx*SPB+SPB-1
//   beat_data : packed samples of one beat
//   rd_data   : whole frame, PE p at [p*DATA_WIDTH +: DATA_WIDTH]
// Contents are deliberately not reset; the owner tracks validity.
module kan_feeder_bank
    import kan_tda_pkg::*;
#(
    parameter int NUM_PES    = 64,
    parameter int DATA_WIDTH = 16,
    parameter int BEAT_WIDTH = 256,
    localparam int BPF       = calc_bpf(NUM_PES, calc_spb(BEAT_WIDTH, DATA_WIDTH)),
    localparam int BI_W      = idx_w(BPF)
) (
    input  logic                          clk,
    input  logic                          we,
    input  logic [BI_W-1:0]               beat_idx,
    input  logic [BEAT_WIDTH-1:0]         beat_data,
    output logic [NUM_PES*DATA_WIDTH-1:0] rd_data
);

    // One register per beat slot so each slot has a single writer.
    for (genvar b = 0; b < BPF; b++) begin : gen_slot
        logic [BEAT_WIDTH-1:0] seg;

        always_ff @(posedge clk) begin
            if (we && beat_idx == BI_W'(b))
                seg <= beat_data;
        end

        assign rd_data[b*BEAT_WIDTH +: BEAT_WIDTH] = seg;
    end

endmodule

// File: rtl/kan_pe_feeder.sv
// Unpacks memory read beats into double-buffered frames for the KAN PE array.
//   ui_clk, ui_rst_n        : clock, async active-low reset
//   in_data/valid/last/ready: beat stream, in_last on the final beat of a frame
//   out_data/valid/ready    : frame handshake toward the PE array
//   flush                   : drop all buffered and partial frames
//   err_clear, frame_error  : sticky framing error and its clear
//   frame_count             : frames delivered, wraps at 2^32
module kan_pe_feeder
    import kan_tda_pkg::*;
#(
    parameter int NUM_PES    = 64,
    parameter int DATA_WIDTH = 16,
    parameter int BEAT_WIDTH = 256
) (
    input  logic                          ui_clk,
    input  logic                          ui_rst_n,
    input  logic [BEAT_WIDTH-1:0]         in_data,
    input  logic                          in_valid,
    input  logic                          in_last,
    output logic                          in_ready,
    output logic [NUM_PES*DATA_WIDTH-1:0] out_data,
    output logic                          out_valid,
    input  logic                          out_ready,
    input  logic                          flush,
    input  logic                          err_clear,
    output logic                          frame_error,
    output logic [31:0]                   frame_count
);

    localparam int SPB  = calc_spb(BEAT_WIDTH, DATA_WIDTH);
    localparam int BPF  = calc_bpf(NUM_PES, SPB);
    localparam int BC_W = idx_w(BPF);
    localparam int FW   = NUM_PES * DATA_WIDTH;

    logic [1:0]        full;
    logic              wb, rb;
    logic [BC_W-1:0]   bc;
    logic [1:0][FW-1:0] bank_rd;

    logic accept, drain, last_beat, bad_frame;

    assign in_ready  = !full[wb] && !flush;
    assign out_valid = full[rb];
    assign out_data  = bank_rd[rb];

    assign accept    = in_valid && in_ready;
    assign drain     = out_valid && out_ready && !flush;
    assign last_beat = (bc == BC_W'(BPF-1));
    // in_last must coincide exactly with the final beat slot
    assign bad_frame = accept && (in_last != last_beat);

    for (genvar g = 0; g < 2; g++) begin : gen_bank
        kan_feeder_bank #(
            .NUM_PES   (NUM_PES),
            .DATA_WIDTH(DATA_WIDTH),
            .BEAT_WIDTH(BEAT_WIDTH)
        ) u_bank (
            .clk      (ui_clk),
            .we       (accept && (wb == 1'(g))),
            .beat_idx (bc),
            .beat_data(in_data),
            .rd_data  (bank_rd[g])
        );
    end

    // Fill and drain never target the same bank: a fill needs !full[wb],
    // a drain needs full[rb], so both element updates can coexist.
    always_ff @(posedge ui_clk or negedge ui_rst_n) begin
        if (!ui_rst_n) begin
            full        <= '0;
            wb          <= 1'b0;
            rb          <= 1'b0;
            bc          <= '0;
            frame_count <= '0;
        end else if (flush) begin
            full <= '0;
            wb   <= 1'b0;
            rb   <= 1'b0;
            bc   <= '0;
        end else begin
            if (accept) begin
                if (in_last && last_beat) begin
                    full[wb] <= 1'b1;
                    wb       <= ~wb;
                    bc       <= '0;
                end else if (!in_last && !last_beat) begin
                    bc <= bc + 1'b1;
                end else begin
                    bc <= '0;   // framing error: partial frame is dropped
                end
            end
            if (drain) begin
                full[rb]    <= 1'b0;
                rb          <= ~rb;
                frame_count <= frame_count + 32'd1;
            end
        end
    end

    // A new error outranks a clear in the same cycle.
    always_ff @(posedge ui_clk or negedge ui_rst_n) begin
        if (!ui_rst_n)
            frame_error <= 1'b0;
        else if (bad_frame)
            frame_error <= 1'b1;
        else if (err_clear)
            frame_error <= 1'b0;
    end

endmodule

// File: tb/tb_kan_pe_feeder.sv
// Directed bench for kan_pe_feeder at default parameters (64 PEs, 16-bit, 4 beats/frame).
module tb_kan_pe_feeder;
    import kan_tda_pkg::*;

    logic            ui_clk = 1'b0;
    logic            ui_rst_n;
    logic [255:0]    in_data;
    logic            in_valid, in_last, in_ready;
    logic [1023:0]   out_data;
    logic            out_valid, out_ready;
    logic            flush, err_clear, frame_error;
    logic [31:0]     frame_count;

    int errs   = 0;
    int checks = 0;

    kan_pe_feeder dut (
        .ui_clk     (ui_clk),
        .ui_rst_n   (ui_rst_n),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .in_last    (in_last),
        .in_ready   (in_ready),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .flush      (flush),
        .err_clear  (err_clear),
        .frame_error(frame_error),
        .frame_count(frame_count)
    );

    always #5 ui_clk = ~ui_clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Lane p of a frame with base b carries b+p.
    function automatic logic [255:0] mk_beat(input int b, input int base);
        logic [255:0] v;
        kan_sample_t  s;
        for (int j = 0; j < 16; j++) begin
            s = kan_sample_t'(base + b*16 + j);
            v[j*16 +: 16] = s;
        end
        return v;
    endfunction

    function automatic int bad_lanes(input logic [1023:0] d, input int base);
        int n = 0;
        for (int p = 0; p < 64; p++)
            if (d[p*16 +: 16] !== 16'(base + p)) n++;
        return n;
    endfunction

    task automatic chk_frame(input string tag, input int base);
        chk({tag, "_valid"}, 64'(out_valid), 64'd1);
        chk({tag, "_bad_lanes"}, 64'(bad_lanes(out_data, base)), 64'd0);
    endtask

    // Present one beat and return 1ns after the edge that accepts it.
    task automatic send_beat(input int b, input int base, input logic last);
        int n = 0;
        in_data  = mk_beat(b, base);
        in_valid = 1'b1;
        in_last  = last;
        @(negedge ui_clk);
        while (in_ready !== 1'b1 && n < 50) begin
            @(negedge ui_clk);
            n++;
        end
        if (n >= 50) chk("beat_timeout", 64'd1, 64'd0);
        @(posedge ui_clk);
        #1;
    endtask

    // last_at < 0 means no beat carries in_last.
    task automatic send_frame(input int base, input int nbeats, input int last_at);
        for (int b = 0; b < nbeats; b++)
            send_beat(b, base, (b == last_at));
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic wait_frame(input string tag, input int base);
        int n = 0;
        @(negedge ui_clk);
        while (out_valid !== 1'b1 && n < 50) begin
            @(negedge ui_clk);
            n++;
        end
        chk_frame(tag, base);
    endtask

    initial begin
        ui_rst_n  = 1'b0;
        in_data   = '0;
        in_valid  = 1'b0;
        in_last   = 1'b0;
        out_ready = 1'b0;
        flush     = 1'b0;
        err_clear = 1'b0;
        #12;
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_frame_error", 64'(frame_error), 64'd0);
        chk("rst_frame_count", 64'(frame_count), 64'd0);
        @(negedge ui_clk);
        ui_rst_n = 1'b1;
        @(posedge ui_clk);
        #1;

        // Single frame, consumer always ready
        out_ready = 1'b1;
        send_frame(0, 3, -1);
        @(negedge ui_clk);
        chk("single_pre_valid", 64'(out_valid), 64'd0);
        @(posedge ui_clk);
        #1;
        send_beat(3, 0, 1'b1);
        in_valid = 1'b0;
        in_last  = 1'b0;
        @(negedge ui_clk);
        chk_frame("single", 0);
        @(negedge ui_clk);
        chk("single_one_cycle", 64'(out_valid), 64'd0);
        chk("single_count", 64'(frame_count), 64'd1);

        // Backpressure: two frames fill both banks, third stalls
        @(posedge ui_clk);
        #1;
        out_ready = 1'b0;
        send_frame(100, 4, 3);
        send_frame(200, 4, 3);
        in_data  = mk_beat(0, 300);
        in_valid = 1'b1;
        @(negedge ui_clk);
        chk("bp_in_ready", 64'(in_ready), 64'd0);
        chk_frame("bp_f0", 100);
        repeat (3) @(negedge ui_clk);
        chk_frame("bp_f0_hold", 100);
        chk("bp_in_ready_hold", 64'(in_ready), 64'd0);
        @(posedge ui_clk);
        #1;
        out_ready = 1'b1;
        fork
            send_frame(300, 4, 3);
            begin
                wait_frame("bp_f0_out", 100);
                wait_frame("bp_f1_out", 200);
                wait_frame("bp_f2_out", 300);
            end
        join
        @(negedge ui_clk);
        chk("bp_drained", 64'(out_valid), 64'd0);
        chk("bp_count", 64'(frame_count), 64'd4);

        // Early last on beat 1
        @(posedge ui_clk);
        #1;
        send_frame(0, 2, 1);
        @(negedge ui_clk);
        chk("early_err", 64'(frame_error), 64'd1);
        chk("early_no_valid", 64'(out_valid), 64'd0);
        @(posedge ui_clk);
        #1;
        send_frame(400, 4, 3);
        wait_frame("early_next", 400);
        @(negedge ui_clk);
        chk("early_count", 64'(frame_count), 64'd5);
        chk("early_err_sticky", 64'(frame_error), 64'd1);
        @(posedge ui_clk);
        #1;
        err_clear = 1'b1;
        @(posedge ui_clk);
        #1;
        err_clear = 1'b0;
        @(negedge ui_clk);
        chk("early_err_cleared", 64'(frame_error), 64'd0);

        // Missing last: four beats without in_last
        @(posedge ui_clk);
        #1;
        send_frame(0, 4, -1);
        @(negedge ui_clk);
        chk("miss_err", 64'(frame_error), 64'd1);
        repeat (2) @(negedge ui_clk);
        chk("miss_no_valid", 64'(out_valid), 64'd0);
        chk("miss_count", 64'(frame_count), 64'd5);
        @(posedge ui_clk);
        #1;
        err_clear = 1'b1;
        @(posedge ui_clk);
        #1;
        err_clear = 1'b0;
        @(negedge ui_clk);
        chk("miss_err_cleared", 64'(frame_error), 64'd0);

        // Error set outranks a simultaneous clear
        @(posedge ui_clk);
        #1;
        err_clear = 1'b1;
        send_beat(0, 0, 1'b1);
        err_clear = 1'b0;
        in_valid  = 1'b0;
        in_last   = 1'b0;
        @(negedge ui_clk);
        chk("set_beats_clear", 64'(frame_error), 64'd1);

        // Flush with one full frame and a partial one buffered
        @(posedge ui_clk);
        #1;
        out_ready = 1'b0;
        send_frame(500, 4, 3);
        send_frame(600, 2, -1);
        flush = 1'b1;
        @(negedge ui_clk);
        chk("flush_in_ready_low", 64'(in_ready), 64'd0);
        @(posedge ui_clk);
        #1;
        flush = 1'b0;
        @(negedge ui_clk);
        chk("flush_out_valid", 64'(out_valid), 64'd0);
        chk("flush_in_ready", 64'(in_ready), 64'd1);
        chk("flush_count", 64'(frame_count), 64'd5);
        chk("flush_err_kept", 64'(frame_error), 64'd1);
        @(posedge ui_clk);
        #1;
        out_ready = 1'b1;
        send_frame(700, 4, 3);
        wait_frame("flush_next", 700);
        @(negedge ui_clk);
        chk("flush_next_count", 64'(frame_count), 64'd6);

        // Reset mid-frame with a complete frame waiting
        @(posedge ui_clk);
        #1;
        out_ready = 1'b0;
        send_frame(800, 4, 3);
        send_frame(850, 2, -1);
        #2;
        ui_rst_n = 1'b0;
        #1;
        chk("rst2_in_ready", 64'(in_ready), 64'd1);
        chk("rst2_out_valid", 64'(out_valid), 64'd0);
        chk("rst2_frame_error", 64'(frame_error), 64'd0);
        chk("rst2_frame_count", 64'(frame_count), 64'd0);
        repeat (2) @(negedge ui_clk);
        ui_rst_n = 1'b1;
        @(posedge ui_clk);
        #1;
        out_ready = 1'b1;
        send_frame(900, 4, 3);
        wait_frame("rst2_next", 900);
        @(negedge ui_clk);
        chk("rst2_next_count", 64'(frame_count), 64'd1);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
